// File: rtl/hp35_resp_pkg.sv
// Shared constants for the hp35 ROM responder: register offsets, CTRL bit positions, WB FSM states.
package hp35_resp_pkg;

    localparam logic [11:0] OFS_CTRL  = 12'h000;
    localparam logic [11:0] OFS_BKPT  = 12'h004;
    localparam logic [11:0] OFS_STATS = 12'h008;
    localparam logic [11:0] OFS_LAST  = 12'h00C;
    localparam logic [11:0] OFS_ROM   = 12'h400;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_BKPT_EN = 1;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/hp35_rom_responder_if.sv
// Wishbone slave bus bundle between the management SoC and the ROM responder.
interface hp35_rom_responder_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/hp35_edge_sync.sv
// Two-flop synchroniser for an asynchronous level plus a one-cycle rising-edge pulse.
module hp35_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/hp35_rom_responder.sv
// Wishbone-loadable microcode ROM answering hp35_core fetches; fetch latency 3 wb_clk_i edges after sync.
// Optional fetch counter in STATS is built only when HP35_RESP_STATS_EN is defined.
module hp35_rom_responder
    import hp35_resp_pkg::*;
#(
    parameter int          AW        = 8,
    parameter int          DW        = 30,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    hp35_rom_responder_if.slave   wbs,
    input  logic                  sram_clk1,
    input  logic [AW-1:0]         sraddr_mux,
    output logic [DW-1:0]         srdata,
    output logic                  bkpt_irq
);

    wb_state_t     state_q, state_d;
    logic          start, wr;
    logic [11:0]   ofs;
    logic          hit, rom_hit;
    logic [AW-1:0] rom_idx;
    logic [31:0]   rd_dat, dat_q;
    logic [1:0]    ctrl;
    logic [AW-1:0] bkpt_addr, last_addr;
    logic          fetch_rise, fetch_pend;
    logic [DW-1:0] rom [2**AW];
    logic          unused_bits;

    assign ofs     = wbs.wbs_adr_i[11:0];
    assign hit     = wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12];
    assign rom_hit = (int'(ofs) >= int'(OFS_ROM)) && (int'(ofs) < int'(OFS_ROM) + (4 << AW));
    assign rom_idx = wbs.wbs_adr_i[AW+1:2];
    assign wr      = start & wbs.wbs_we_i;
    assign unused_bits = ^wbs.wbs_dat_i[31:30];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= WB_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            WB_IDLE: if (wbs.wbs_cyc_i && wbs.wbs_stb_i && hit) begin
                state_d = WB_ACK;
                start   = 1'b1;
            end
            WB_ACK:  state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

`ifdef HP35_RESP_STATS_EN
    logic [15:0] stats;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            stats <= '0;
        else if (wr && !rom_hit && ofs[11:2] == OFS_STATS[11:2])
            stats <= '0;
        else if (fetch_rise && stats != 16'hFFFF)
            stats <= stats + 16'd1;
    end
`endif

    always_comb begin
        rd_dat = '0;
        if (rom_hit) begin
            rd_dat = {{(32-DW){1'b0}}, rom[rom_idx]};
        end else begin
            case (ofs[11:2])
                OFS_CTRL[11:2]:  rd_dat = {30'b0, ctrl};
                OFS_BKPT[11:2]:  rd_dat = {{(32-AW){1'b0}}, bkpt_addr};
`ifdef HP35_RESP_STATS_EN
                OFS_STATS[11:2]: rd_dat = {16'b0, stats};
`endif
                OFS_LAST[11:2]:  rd_dat = {{(32-AW){1'b0}}, last_addr};
                default:         rd_dat = '0;
            endcase
        end
    end

    // Read data is only presented during the ack cycle; zero otherwise.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            dat_q     <= '0;
            ctrl      <= '0;
            bkpt_addr <= '0;
        end else begin
            dat_q <= (start && !wbs.wbs_we_i) ? rd_dat : '0;
            if (wr && !rom_hit && ofs[11:2] == OFS_CTRL[11:2])
                ctrl <= wbs.wbs_dat_i[1:0];
            if (wr && !rom_hit && ofs[11:2] == OFS_BKPT[11:2])
                bkpt_addr <= wbs.wbs_dat_i[AW-1:0];
        end
    end

    assign wbs.wbs_ack_o = (state_q == WB_ACK);
    assign wbs.wbs_dat_o = dat_q;

    // Array is not reset; the top lane carries only bits DW-1:24.
    always_ff @(posedge wb_clk_i) begin
        if (wr && rom_hit) begin
            if (wbs.wbs_sel_i[0]) rom[rom_idx][7:0]     <= wbs.wbs_dat_i[7:0];
            if (wbs.wbs_sel_i[1]) rom[rom_idx][15:8]    <= wbs.wbs_dat_i[15:8];
            if (wbs.wbs_sel_i[2]) rom[rom_idx][23:16]   <= wbs.wbs_dat_i[23:16];
            if (wbs.wbs_sel_i[3]) rom[rom_idx][DW-1:24] <= wbs.wbs_dat_i[DW-1:24];
        end
    end

    hp35_edge_sync u_sync (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .din  (sram_clk1),
        .rise (fetch_rise)
    );

    // A same-edge ROM write is not visible here: the fetch sees the old word.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            fetch_pend <= 1'b0;
            last_addr  <= '0;
            srdata     <= '0;
            bkpt_irq   <= 1'b0;
        end else begin
            fetch_pend <= fetch_rise;
            if (fetch_rise)
                last_addr <= sraddr_mux;
            if (fetch_pend)
                srdata <= ctrl[CTRL_EN] ? rom[last_addr] : '0;
            bkpt_irq <= fetch_pend && ctrl[CTRL_BKPT_EN] && (last_addr == bkpt_addr);
        end
    end

endmodule

// File: tb/tb_hp35_rom_responder.sv
// Scoreboarded bench for hp35_rom_responder: Wishbone accesses and ROM fetches.
module tb_hp35_rom_responder;

    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef HP35_RESP_STATS_EN
    localparam logic [31:0] STATS_EXP = 32'd3;
`else
    localparam logic [31:0] STATS_EXP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sram_clk1 = 1'b0;
    logic [7:0]  sraddr_mux = 8'h00;
    logic [29:0] srdata;
    logic        bkpt_irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    hp35_rom_responder_if bus();

    hp35_rom_responder #(
        .AW        (8),
        .DW        (30),
        .BASE_ADDR (BASE)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs        (bus.slave),
        .sram_clk1  (sram_clk1),
        .sraddr_mux (sraddr_mux),
        .srdata     (srdata),
        .bkpt_irq   (bkpt_irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_access(input logic [11:0] ofs, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, input logic [31:0] exp_rd);
        bit got;
        logic [31:0] e;
        got = 1'b0;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = BASE | {20'b0, ofs};
        bus.wbs_dat_i = dat;
        if (!we) exp_q.push_back(exp_rd);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check_val("ack_timeout", 32'd0, 32'd1);
            if (!we) e = exp_q.pop_front();
        end else if (!we) begin
            e = exp_q.pop_front();
            check_val("rd_dat", bus.wbs_dat_o, e);
        end
        bus_idle();
        if (got) begin
            @(posedge clk); #1;
            check_val("ack_one_cycle", {31'b0, bus.wbs_ack_o}, 32'd0);
            check_val("dat_zero_after_ack", bus.wbs_dat_o, 32'd0);
        end
    endtask

    task automatic wr(input logic [11:0] ofs, input logic [31:0] dat, input logic [3:0] sel);
        wb_access(ofs, 1'b1, dat, sel, 32'd0);
    endtask

    task automatic rd(input logic [11:0] ofs, input logic [31:0] exp);
        wb_access(ofs, 1'b0, 32'd0, 4'hF, exp);
    endtask

    task automatic fetch(input logic [7:0] a, input logic [29:0] exp_d, input logic exp_irq);
        logic [31:0] e;
        @(negedge clk);
        sraddr_mux = a;
        sram_clk1  = 1'b1;
        exp_q.push_back({2'b0, exp_d});
        repeat (3) @(posedge clk);
        #1 check_val("irq_early", {31'b0, bkpt_irq}, 32'd0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        check_val("srdata", {2'b0, srdata}, e);
        check_val("bkpt_irq", {31'b0, bkpt_irq}, {31'b0, exp_irq});
        @(posedge clk); #1;
        check_val("irq_width", {31'b0, bkpt_irq}, 32'd0);
        check_val("srdata_hold", {2'b0, srdata}, e);
        @(negedge clk) sram_clk1 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] e;
        bit got;
        bus_idle();
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        check_val("rst_dat", bus.wbs_dat_o, 32'd0);
        check_val("rst_srdata", {2'b0, srdata}, 32'd0);
        check_val("rst_irq", {31'b0, bkpt_irq}, 32'd0);
        @(negedge clk) rst = 1'b0;
        rd(12'h000, 32'd0);
        rd(12'h004, 32'd0);
        rd(12'h00C, 32'd0);

        // Full-word load and enabled fetch
        wr(12'h400, 32'h2AAA_5555, 4'hF);
        wr(12'h000, 32'd1, 4'hF);
        rd(12'h400, 32'h2AAA_5555);
        fetch(8'h00, 30'h2AAA_5555, 1'b0);

        // Byte lanes, including the narrow top lane
        wr(12'h40C, 32'h0, 4'hF);
        wr(12'h40C, 32'hFFFF_FFFF, 4'b0001);
        rd(12'h40C, 32'h0000_00FF);
        wr(12'h410, 32'h0, 4'hF);
        wr(12'h410, 32'hFFFF_FFFF, 4'b1000);
        rd(12'h410, 32'h3F00_0000);
        wr(12'h410, 32'hFFFF_FFFF, 4'b0110);
        rd(12'h410, 32'h3FFF_FF00);
        wr(12'h7FC, 32'h1234_5678, 4'hF);
        rd(12'h7FC, 32'h1234_5678);

        // Breakpoint fires only on the matching fetch
        wr(12'h400 + 12'h1F8, 32'h111, 4'hF);
        wr(12'h400 + 12'h1FC, 32'h222, 4'hF);
        wr(12'h000, 32'd3, 4'hF);
        wr(12'h004, 32'h7F, 4'hF);
        rd(12'h000, 32'd3);
        rd(12'h004, 32'h7F);
        fetch(8'h7E, 30'h111, 1'b0);
        fetch(8'h7F, 30'h222, 1'b1);

        // Disabled fetch still records the address; unmapped offsets
        wr(12'h000, 32'd0, 4'hF);
        fetch(8'h05, 30'h0, 1'b0);
        rd(12'h00C, 32'h05);
        rd(12'h800, 32'd0);
        wr(12'h800, 32'hDEAD_BEEF, 4'hF);
        rd(12'h800, 32'd0);

        // Outside the base window: never acked
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = BASE + 32'h1000;
        got = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) got = 1'b1;
        end
        check_val("miss_no_ack", {31'b0, got}, 32'd0);
        bus_idle();

        // Same-edge write and fetch of word 9
        wr(12'h424, 32'd0, 4'hF);
        wr(12'h000, 32'd1, 4'hF);
        @(negedge clk);
        sraddr_mux = 8'h09;
        sram_clk1  = 1'b1;
        exp_q.push_back(32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = BASE | 32'h424;
        bus.wbs_dat_i = 32'd1;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        check_val("coll_srdata", {2'b0, srdata}, e);
        check_val("coll_ack", {31'b0, bus.wbs_ack_o}, 32'd1);
        bus_idle();
        @(negedge clk) sram_clk1 = 1'b0;
        repeat (4) @(negedge clk);
        fetch(8'h09, 30'd1, 1'b0);

        // Fetch counter
        wr(12'h008, 32'd0, 4'hF);
        repeat (3) fetch(8'h00, 30'h2AAA_5555, 1'b0);
        rd(12'h008, STATS_EXP);
        wr(12'h008, 32'd0, 4'hF);
        rd(12'h008, 32'd0);

        // Reset during an ack cycle
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = BASE | 32'h400;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        check_val("pre_rst_ack", {31'b0, got}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        check_val("mid_rst_dat", bus.wbs_dat_o, 32'd0);
        check_val("mid_rst_srdata", {2'b0, srdata}, 32'd0);
        bus_idle();
        @(negedge clk) rst = 1'b0;
        rd(12'h000, 32'd0);
        rd(12'h004, 32'd0);
        wr(12'h000, 32'd1, 4'hF);
        fetch(8'h00, 30'h2AAA_5555, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
